// File: rtl/scan_display_driver_pkg.sv
// scan_display_driver_pkg: segment patterns, converter states and width helpers
// shared by the BCD converter and the scan driver.
package scan_display_driver_pkg;

    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        return (n < 4'd10) ? SEG_TABLE[n] : SEG_OFF;
    endfunction

    function automatic int clog2_w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic longint unsigned pow10(input int k);
        longint unsigned r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/scan_display_driver_bcd_seq_converter.sv
// bcd_seq_converter: sequential shift-add-3 binary to BCD converter with
// valid/ready load and an atomic commit of digits and overflow flag.
module bcd_seq_converter
    import scan_display_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 5,
    parameter int VALUE_W    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [VALUE_W-1:0]      i_value,
    input  logic                    i_load,
    output logic                    o_ready,
    output logic [4*NUM_DIGITS-1:0] o_digits,
    output logic                    o_ovf
);
    localparam int CW = clog2_w(VALUE_W);
    localparam longint unsigned LIMIT = pow10(NUM_DIGITS);

    conv_state_t             r_state;
    logic [VALUE_W-1:0]      r_bin;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [4*NUM_DIGITS-1:0] w_adj;
    logic [CW-1:0]           r_cnt;
    logic                    r_ovf_pend;

    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < NUM_DIGITS; k++)
            w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            o_ready    <= 1'b1;
            o_digits   <= '0;
            o_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_load) begin
                    r_state    <= S_SHIFT;
                    r_bin      <= i_value;
                    r_bcd      <= '0;
                    r_cnt      <= '0;
                    r_ovf_pend <= 64'(i_value) >= LIMIT;
                    o_ready    <= 1'b0;
                end
                S_SHIFT: begin
                    r_bcd   <= {w_adj[4*NUM_DIGITS-2:0], r_bin[VALUE_W-1]};
                    r_bin   <= r_bin << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= (r_cnt == CW'(VALUE_W-1)) ? S_COMMIT : S_SHIFT;
                end
                S_COMMIT: begin
                    o_digits <= r_bcd;
                    o_ovf    <= r_ovf_pend;
                    o_ready  <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/scan_display_driver.sv
// scan_display_driver: multiplexed 7-segment driver with BCD conversion,
// leading-zero blanking, decimal points, overflow dashes and anti-ghost guard.
module scan_display_driver
    import scan_display_driver_pkg::*;
#(
    parameter int NUM_DIGITS  = 5,
    parameter int VALUE_W     = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [VALUE_W-1:0]    value_in,
    input  logic                  load,
    output logic                  ready,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  ovf,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);
    localparam int IW = clog2_w(NUM_DIGITS);
    localparam int PW = clog2_w(REFRESH_DIV);

    logic [4*NUM_DIGITS-1:0] w_digits;
    logic [IW-1:0]           r_idx;
    logic [PW-1:0]           r_pre;
    logic [3:0]              w_nib;
    logic                    w_upper_zero;
    logic                    w_blank;
    logic                    w_tc;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_an;
    logic                    w_dp;

    bcd_seq_converter #(
        .NUM_DIGITS (NUM_DIGITS),
        .VALUE_W    (VALUE_W)
    ) u_conv (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_value  (value_in),
        .i_load   (load),
        .o_ready  (ready),
        .o_digits (w_digits),
        .o_ovf    (ovf)
    );

    // Upper-zero scan covers the selected digit and every more significant one.
    always_comb begin
        w_nib        = 4'd0;
        w_upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == r_idx) w_nib = w_digits[4*k +: 4];
            if (IW'(k) >= r_idx && w_digits[4*k +: 4] != 4'd0) w_upper_zero = 1'b0;
        end
        w_blank = blank_lz && (r_idx != '0) && w_upper_zero;
        w_seg   = ovf ? SEG_DASH : w_blank ? SEG_OFF : seg_decode(w_nib);
        w_dp    = !ovf && dp_mask[r_idx];
        w_an    = (r_pre < PW'(GUARD)) ? '0 : NUM_DIGITS'(1) << r_idx;
        w_tc    = (r_pre == PW'(REFRESH_DIV-1));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pre <= '0;
            r_idx <= '0;
            an    <= {NUM_DIGITS{ACTIVE_LOW}};
            seg   <= SEG_OFF ^ {7{ACTIVE_LOW}};
            dp    <= ACTIVE_LOW;
        end else begin
            r_pre <= w_tc ? '0 : r_pre + 1'b1;
            r_idx <= !w_tc ? r_idx : (r_idx == IW'(NUM_DIGITS-1)) ? '0 : r_idx + 1'b1;
            an    <= w_an ^ {NUM_DIGITS{ACTIVE_LOW}};
            seg   <= w_seg ^ {7{ACTIVE_LOW}};
            dp    <= w_dp ^ ACTIVE_LOW;
        end
    end

endmodule
